// File: rtl/clk_div_multi.sv
// Multi-channel clock divider: shared counter, per-channel phase/invert, registered clk_out/tick (1-cycle latency).
// Divide-ratio changes are handshaken via div_req/div_ack at wrap; tick logic exists only with CLK_DIV_MULTI_TICK_EN.
module clk_div_multi #(
    parameter int NCH         = 4,
    parameter int CW          = 4,
    parameter int DEFAULT_DIV = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              div_req,
    input  logic [CW-1:0]     div_val,
    input  logic [NCH*CW-1:0] phase,
    input  logic [NCH-1:0]    invert,
    output logic [NCH-1:0]    clk_out,
    output logic [NCH-1:0]    tick,
    output logic              div_ack,
    output logic              div_err,
    output logic [CW-1:0]     div_cur
);

    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  r_div;
    logic [NCH-1:0] r_clk;
    logic           r_ack;
    logic           r_err;

    logic [CW-1:0]  w_half;
    logic           w_wrap;
    logic           w_req_ok;
    logic [CW-1:0]  w_off [NCH];

    assign w_half   = r_div >> 1;
    assign w_wrap   = (r_cnt == r_div - CW'(1));
    assign w_req_ok = (div_val >= CW'(2));

    // Out-of-range phase collapses to 0; both operands are < r_div so the sum cannot overflow.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [CW-1:0] w_ph;
        assign w_ph     = (phase[g*CW +: CW] >= r_div) ? '0 : phase[g*CW +: CW];
        assign w_off[g] = (r_cnt >= w_ph) ? (r_cnt - w_ph) : (r_cnt + (r_div - w_ph));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt <= '0;
            r_div <= CW'(DEFAULT_DIV);
            r_clk <= '0;
            r_ack <= 1'b0;
            r_err <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                r_clk[i] <= (w_off[i] < w_half) ^ invert[i];
            end
            r_ack <= w_wrap && div_req;
            r_err <= w_wrap && div_req && !w_req_ok;
            if (w_wrap) begin
                r_cnt <= '0;
                if (div_req && w_req_ok) begin
                    r_div <= div_val;
                end
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

`ifdef CLK_DIV_MULTI_TICK_EN
    logic [NCH-1:0] r_tick;

    // Tick marks the rising edge of the post-inversion output.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_tick <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                r_tick[i] <= invert[i] ? (w_off[i] == w_half) : (w_off[i] == '0);
            end
        end
    end

    assign tick = r_tick;
`else
    assign tick = '0;
`endif

    assign clk_out = r_clk;
    assign div_ack = r_ack;
    assign div_err = r_err;
    assign div_cur = r_div;

endmodule
